// File: rtl/lc3b_control_ext_pkg.sv
// Shared types for the extended LC-3b multicycle control unit: opcodes, ALU ops,
// datapath mux selects and controller states.
package lc3b_control_ext_pkg;

  // 4'b1010/4'b1011 are reserved; LDI/STI live in the RTI/SHF slots.
  typedef enum logic [3:0] {
    op_br   = 4'h0, op_add  = 4'h1, op_ldb = 4'h2, op_stb  = 4'h3,
    op_jsr  = 4'h4, op_and  = 4'h5, op_ldr = 4'h6, op_str  = 4'h7,
    op_ldi  = 4'h8, op_not  = 4'h9, op_jmp = 4'hc, op_sti  = 4'hd,
    op_lea  = 4'he, op_trap = 4'hf
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
  } lc3b_aluop;

  typedef enum logic [1:0] {
    pcmux_plus2, pcmux_br_add, pcmux_alu, pcmux_mdr
  } lc3b_pcmux_sel;

  typedef enum logic [1:0] {
    marmux_alu, marmux_pc, marmux_trapvect, marmux_mdr
  } lc3b_marmux_sel;

  typedef enum logic [1:0] {
    regmux_alu, regmux_mdr, regmux_pc, regmux_br_add
  } lc3b_regmux_sel;

  typedef enum logic [4:0] {
    fetch1, fetch2, fetch3, decode,
    s_add, s_and, s_not, br, br_taken, calc_addr,
    ldr1, ldr2, ldb1, ldb2, str1, str2, stb1, stb2, ind1, ind2,
    s_lea, s_jmp, jsr1, jsr2, trap1, trap2, trap3, trap4,
    fault, illegal_state
  } lc3b_state;

  // States that hold a memory request open until mem_resp.
  function automatic logic is_mem_state(lc3b_state s);
    return s inside {fetch2, ldr1, ldb1, str2, stb2, ind1, trap3};
  endfunction

endpackage

// File: rtl/lc3b_control_ext_if.sv
// Control/status bundle between the LC-3b controller (master) and datapath/memory (slave).
interface lc3b_control_ext_if #(
  parameter int CNT_WIDTH = 32
);
  import lc3b_control_ext_pkg::*;

  logic [3:0]            opcode;
  logic                  ir11;
  logic                  branch_enable;
  logic                  mar_lsb;
  logic                  mem_resp;

  logic                  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  lc3b_pcmux_sel         pcmux_sel;
  lc3b_marmux_sel        marmux_sel;
  lc3b_regmux_sel        regfilemux_sel;
  logic                  destmux_sel, storemux_sel, alumux_sel, mdrmux_sel, ldbmux_sel;
  lc3b_aluop             aluop;
  logic                  mem_read, mem_write;
  logic [1:0]            mem_byte_enable;
  logic                  mem_error, illegal_op;
  logic [CNT_WIDTH-1:0]  instr_count;

  modport master (
    input  opcode, ir11, branch_enable, mar_lsb, mem_resp,
    output load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
           pcmux_sel, marmux_sel, regfilemux_sel,
           destmux_sel, storemux_sel, alumux_sel, mdrmux_sel, ldbmux_sel,
           aluop, mem_read, mem_write, mem_byte_enable,
           mem_error, illegal_op, instr_count
  );

  modport slave (
    output opcode, ir11, branch_enable, mar_lsb, mem_resp,
    input  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
           pcmux_sel, marmux_sel, regfilemux_sel,
           destmux_sel, storemux_sel, alumux_sel, mdrmux_sel, ldbmux_sel,
           aluop, mem_read, mem_write, mem_byte_enable,
           mem_error, illegal_op, instr_count
  );

endinterface

// File: rtl/lc3b_control_ext_mem_watchdog.sv
// Memory-wait watchdog: counts unanswered cycles of a memory state and pulses
// timeout on the cycle the count would reach MEM_TIMEOUT (0 disables it).
module lc3b_control_ext_mem_watchdog #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic waiting,
  input  logic mem_resp,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start)
      cnt_d = '0;
    else if (waiting && !mem_resp && (cnt_q != '1))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q holds earlier misses; a response this cycle always beats the timeout.
  assign timeout = (MEM_TIMEOUT != 0) && waiting && !mem_resp &&
                   (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/lc3b_control_ext.sv
// Multicycle control FSM for the extended LC-3b datapath, with memory watchdog,
// optional LDI/STI support and a retired-instruction counter.
module lc3b_control_ext
  import lc3b_control_ext_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 255,
  parameter int ENABLE_INDIRECT = 1,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                clk,
  input  logic                reset,
  lc3b_control_ext_if.master  ctl
);

  localparam bit IND_EN = (ENABLE_INDIRECT != 0);

  lc3b_state            state_q, state_d;
  logic                 mem_error_q, mem_error_d;
  logic                 illegal_op_q, illegal_op_d;
  logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;
  logic                 wd_start, wd_waiting, wd_timeout;

  assign wd_waiting = is_mem_state(state_q);
  assign wd_start   = is_mem_state(state_d) && (state_d != state_q);

  lc3b_control_ext_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .start    (wd_start),
    .waiting  (wd_waiting),
    .mem_resp (ctl.mem_resp),
    .timeout  (wd_timeout)
  );

  always_comb begin
    state_d         = state_q;
    mem_error_d     = mem_error_q;
    illegal_op_d    = illegal_op_q;
    instr_count_d   = instr_count_q;

    ctl.load_pc         = 1'b0;
    ctl.load_ir         = 1'b0;
    ctl.load_regfile    = 1'b0;
    ctl.load_mar        = 1'b0;
    ctl.load_mdr        = 1'b0;
    ctl.load_cc         = 1'b0;
    ctl.pcmux_sel       = pcmux_plus2;
    ctl.marmux_sel      = marmux_alu;
    ctl.regfilemux_sel  = regmux_alu;
    ctl.destmux_sel     = 1'b0;
    ctl.storemux_sel    = 1'b0;
    ctl.alumux_sel      = 1'b0;
    ctl.mdrmux_sel      = 1'b0;
    ctl.ldbmux_sel      = 1'b0;
    ctl.aluop           = alu_add;
    ctl.mem_read        = 1'b0;
    ctl.mem_write       = 1'b0;
    ctl.mem_byte_enable = 2'b11;

    case (state_q)
      fetch1: begin
        ctl.load_mar   = 1'b1;
        ctl.marmux_sel = marmux_pc;
        ctl.load_pc    = 1'b1;
        state_d        = fetch2;
      end
      fetch2: begin
        ctl.mem_read   = 1'b1;
        ctl.mdrmux_sel = 1'b1;
        ctl.load_mdr   = 1'b1;
        if (ctl.mem_resp) state_d = fetch3;
      end
      fetch3: begin
        ctl.load_ir = 1'b1;
        state_d     = decode;
      end
      decode: begin
        case (ctl.opcode)
          op_add:  state_d = s_add;
          op_and:  state_d = s_and;
          op_not:  state_d = s_not;
          op_br:   state_d = br;
          op_ldr, op_ldb, op_str, op_stb: state_d = calc_addr;
          op_ldi, op_sti: begin
            if (IND_EN) state_d = calc_addr;
            else begin
              state_d      = illegal_state;
              illegal_op_d = 1'b1;
            end
          end
          op_lea:  state_d = s_lea;
          op_jmp:  state_d = s_jmp;
          op_jsr:  state_d = jsr1;
          op_trap: state_d = trap1;
          default: begin
            state_d      = illegal_state;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      s_add, s_and, s_not: begin
        ctl.aluop        = (state_q == s_add) ? alu_add :
                           (state_q == s_and) ? alu_and : alu_not;
        ctl.load_regfile = 1'b1;
        ctl.load_cc      = 1'b1;
        state_d          = fetch1;
      end
      br:       state_d = ctl.branch_enable ? br_taken : fetch1;
      br_taken: begin
        ctl.load_pc   = 1'b1;
        ctl.pcmux_sel = pcmux_br_add;
        state_d       = fetch1;
      end
      calc_addr: begin
        ctl.alumux_sel = 1'b1;
        ctl.load_mar   = 1'b1;
        case (ctl.opcode)
          op_ldr:  state_d = ldr1;
          op_ldb:  state_d = ldb1;
          op_str:  state_d = str1;
          op_stb:  state_d = stb1;
          default: state_d = ind1;
        endcase
      end
      ldr1, ldb1, ind1, trap3: begin
        ctl.mem_read   = 1'b1;
        ctl.mdrmux_sel = 1'b1;
        ctl.load_mdr   = 1'b1;
        if (ctl.mem_resp)
          state_d = (state_q == ldr1) ? ldr2 :
                    (state_q == ldb1) ? ldb2 :
                    (state_q == ind1) ? ind2 : trap4;
      end
      ldr2, ldb2: begin
        ctl.regfilemux_sel = regmux_mdr;
        ctl.ldbmux_sel     = (state_q == ldb2);
        ctl.load_regfile   = 1'b1;
        ctl.load_cc        = 1'b1;
        state_d            = fetch1;
      end
      // The datapath copies the low source byte into both MDR lanes for STB.
      str1, stb1: begin
        ctl.storemux_sel = 1'b1;
        ctl.aluop        = alu_pass;
        ctl.load_mdr     = 1'b1;
        state_d          = (state_q == str1) ? str2 : stb2;
      end
      str2, stb2: begin
        ctl.mem_write = 1'b1;
        if (state_q == stb2) ctl.mem_byte_enable = ctl.mar_lsb ? 2'b10 : 2'b01;
        if (ctl.mem_resp) state_d = fetch1;
      end
      ind2: begin
        ctl.load_mar   = 1'b1;
        ctl.marmux_sel = marmux_mdr;
        state_d        = (ctl.opcode == op_ldi) ? ldr1 : str1;
      end
      s_lea: begin
        ctl.regfilemux_sel = regmux_br_add;
        ctl.load_regfile   = 1'b1;
        ctl.load_cc        = 1'b1;
        state_d            = fetch1;
      end
      s_jmp: begin
        ctl.aluop     = alu_pass;
        ctl.load_pc   = 1'b1;
        ctl.pcmux_sel = pcmux_alu;
        state_d       = fetch1;
      end
      jsr1, trap1: begin
        ctl.destmux_sel    = 1'b1;
        ctl.regfilemux_sel = regmux_pc;
        ctl.load_regfile   = 1'b1;
        state_d            = (state_q == jsr1) ? jsr2 : trap2;
      end
      // BaseR is read after the R7 write, so JSRR R7 jumps to the new R7.
      jsr2: begin
        ctl.aluop     = alu_pass;
        ctl.load_pc   = 1'b1;
        ctl.pcmux_sel = ctl.ir11 ? pcmux_br_add : pcmux_alu;
        state_d       = fetch1;
      end
      trap2: begin
        ctl.load_mar   = 1'b1;
        ctl.marmux_sel = marmux_trapvect;
        state_d        = trap3;
      end
      trap4: begin
        ctl.load_pc   = 1'b1;
        ctl.pcmux_sel = pcmux_mdr;
        state_d       = fetch1;
      end
      default: ;
    endcase

    if (wd_timeout) begin
      state_d     = fault;
      mem_error_d = 1'b1;
    end

    if ((state_d == fetch1) && (state_q != fetch1))
      instr_count_d = instr_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= fetch1;
      mem_error_q   <= 1'b0;
      illegal_op_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mem_error_q   <= mem_error_d;
      illegal_op_q  <= illegal_op_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign ctl.mem_error   = mem_error_q;
  assign ctl.illegal_op  = illegal_op_q;
  assign ctl.instr_count = instr_count_q;

endmodule

// File: tb/tb_lc3b_control_ext.sv
// Directed bench for lc3b_control_ext: an instruction-level model expands each
// instruction into its expected per-cycle control words and flag/counter values.
module tb_lc3b_control_ext;
  import lc3b_control_ext_pkg::*;

  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam bit IND = 1'b1;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       ir11, branch_enable, mar_lsb, mem_resp;

  always #5 clk = ~clk;

  lc3b_control_ext_if #(.CNT_WIDTH(CW)) ifm ();
  lc3b_control_ext_if #(.CNT_WIDTH(32)) ifn ();

  assign ifm.opcode = opcode;  assign ifm.ir11 = ir11;
  assign ifm.branch_enable = branch_enable;  assign ifm.mar_lsb = mar_lsb;
  assign ifm.mem_resp = mem_resp;
  assign ifn.opcode = opcode;  assign ifn.ir11 = ir11;
  assign ifn.branch_enable = branch_enable;  assign ifn.mar_lsb = mar_lsb;
  assign ifn.mem_resp = mem_resp;

  lc3b_control_ext #(.MEM_TIMEOUT(TMO), .ENABLE_INDIRECT(1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .ctl(ifm));
  lc3b_control_ext #(.MEM_TIMEOUT(TMO), .ENABLE_INDIRECT(0), .CNT_WIDTH(32)) dut_ni (
    .clk(clk), .reset(reset), .ctl(ifn));

  typedef struct packed {
    logic       ld_pc, ld_ir, ld_rf, ld_mar, ld_mdr, ld_cc;
    logic [1:0] pcmux, marmux, rfmux;
    logic       dest, store, alum, mdrm, ldbm;
    logic [2:0] aluop;
    logic       rd, wr;
    logic [1:0] be;
  } ctl_t;

  int         n_tests = 0, n_fail = 0;
  int         exp_cnt;
  bit         exp_err, exp_ill;
  logic [1:0] seen_be, seen_pcmux;
  logic       seen_dest;

  function automatic ctl_t dflt();
    ctl_t c = '0;
    c.aluop = alu_add;
    c.be    = 2'b11;
    return c;
  endfunction

  function automatic ctl_t rd_word();
    ctl_t c = dflt();
    c.rd = 1'b1; c.ld_mdr = 1'b1; c.mdrm = 1'b1;
    return c;
  endfunction

  function automatic ctl_t snap();
    ctl_t c;
    c.ld_pc = ifm.load_pc;  c.ld_ir = ifm.load_ir;  c.ld_rf = ifm.load_regfile;
    c.ld_mar = ifm.load_mar;  c.ld_mdr = ifm.load_mdr;  c.ld_cc = ifm.load_cc;
    c.pcmux = ifm.pcmux_sel;  c.marmux = ifm.marmux_sel;  c.rfmux = ifm.regfilemux_sel;
    c.dest = ifm.destmux_sel;  c.store = ifm.storemux_sel;  c.alum = ifm.alumux_sel;
    c.mdrm = ifm.mdrmux_sel;  c.ldbm = ifm.ldbmux_sel;  c.aluop = ifm.aluop;
    c.rd = ifm.mem_read;  c.wr = ifm.mem_write;  c.be = ifm.mem_byte_enable;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive mem_resp, compare every output to the model, advance.
  task automatic cyc(input ctl_t e, input logic resp, input string nm);
    ctl_t a;
    logic [CW-1:0] ecnt;
    mem_resp = resp;
    #1;
    a    = snap();
    ecnt = CW'(exp_cnt % (1 << CW));
    if (nm == "stb2")  seen_be    = a.be;
    if (nm == "trap1") seen_dest  = a.dest;
    if (nm == "trap4") seen_pcmux = a.pcmux;
    n_tests++;
    if (a !== e || ifm.mem_error !== exp_err || ifm.illegal_op !== exp_ill ||
        ifm.instr_count !== ecnt) begin
      n_fail++;
      $display("FAIL %s: dut ctl=%h err=%b ill=%b cnt=%0d, model ctl=%h err=%b ill=%b cnt=%0d",
               nm, a, ifm.mem_error, ifm.illegal_op, ifm.instr_count, e, exp_err, exp_ill, ecnt);
    end
    @(negedge clk);
  endtask

  // Memory access answered after 'waits' idle cycles, or a watchdog fault.
  task automatic mem(input ctl_t w, input int waits, input string nm, output bit ok);
    bit to = (TMO != 0) && (waits >= TMO);
    ok = 1'b1;
    for (int i = 0; i < (to ? TMO : waits); i++) cyc(w, 1'b0, nm);
    if (to) begin
      exp_err = 1'b1;
      repeat (3) cyc(dflt(), 1'b1, "fault_hold");
      ok = 1'b0;
    end else begin
      cyc(w, 1'b1, nm);
    end
  endtask

  task automatic exec(input logic [3:0] op, input logic i11, input logic ben, input logic lsb,
                      input int fw, input int mw, output bit ok);
    ctl_t w;
    opcode = op; ir11 = i11; branch_enable = ben; mar_lsb = lsb;
    w = dflt(); w.ld_mar = 1'b1; w.marmux = 2'd1; w.ld_pc = 1'b1;
    cyc(w, 1'b0, "fetch1");
    mem(rd_word(), fw, "fetch2", ok);
    if (!ok) return;
    w = dflt(); w.ld_ir = 1'b1;
    cyc(w, 1'b0, "fetch3");
    cyc(dflt(), 1'b0, "decode");
    if (op == 4'b1010 || op == 4'b1011 || (!IND && (op == op_ldi || op == op_sti))) begin
      exp_ill = 1'b1;
      repeat (3) cyc(dflt(), 1'b1, "illegal_hold");
      ok = 1'b0;
      return;
    end
    case (op)
      op_add, op_and, op_not: begin
        w = dflt(); w.ld_rf = 1'b1; w.ld_cc = 1'b1;
        w.aluop = (op == op_add) ? alu_add : (op == op_and) ? alu_and : alu_not;
        cyc(w, 1'b0, "alu");
      end
      op_br: begin
        cyc(dflt(), 1'b0, "br");
        if (ben) begin
          w = dflt(); w.ld_pc = 1'b1; w.pcmux = 2'd1;
          cyc(w, 1'b0, "br_taken");
        end
      end
      op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti: begin
        w = dflt(); w.alum = 1'b1; w.ld_mar = 1'b1;
        cyc(w, 1'b0, "calc_addr");
        if (op == op_ldi || op == op_sti) begin
          mem(rd_word(), mw, "ind1", ok);
          if (!ok) return;
          w = dflt(); w.ld_mar = 1'b1; w.marmux = 2'd3;
          cyc(w, 1'b0, "ind2");
        end
        if (op == op_ldr || op == op_ldb || op == op_ldi) begin
          mem(rd_word(), mw, (op == op_ldb) ? "ldb1" : "ldr1", ok);
          if (!ok) return;
          w = dflt(); w.ld_rf = 1'b1; w.ld_cc = 1'b1; w.rfmux = 2'd1; w.ldbm = (op == op_ldb);
          cyc(w, 1'b0, "load_wb");
        end else begin
          w = dflt(); w.store = 1'b1; w.aluop = alu_pass; w.ld_mdr = 1'b1;
          cyc(w, 1'b0, "str1");
          w = dflt(); w.wr = 1'b1;
          if (op == op_stb) w.be = lsb ? 2'b10 : 2'b01;
          mem(w, mw, (op == op_stb) ? "stb2" : "str2", ok);
          if (!ok) return;
        end
      end
      op_lea: begin
        w = dflt(); w.rfmux = 2'd3; w.ld_rf = 1'b1; w.ld_cc = 1'b1;
        cyc(w, 1'b0, "lea");
      end
      op_jmp: begin
        w = dflt(); w.aluop = alu_pass; w.ld_pc = 1'b1; w.pcmux = 2'd2;
        cyc(w, 1'b0, "jmp");
      end
      op_jsr, op_trap: begin
        w = dflt(); w.dest = 1'b1; w.rfmux = 2'd2; w.ld_rf = 1'b1;
        cyc(w, 1'b0, (op == op_jsr) ? "jsr1" : "trap1");
        if (op == op_jsr) begin
          w = dflt(); w.aluop = alu_pass; w.ld_pc = 1'b1; w.pcmux = i11 ? 2'd1 : 2'd2;
          cyc(w, 1'b0, "jsr2");
        end else begin
          w = dflt(); w.ld_mar = 1'b1; w.marmux = 2'd2;
          cyc(w, 1'b0, "trap2");
          mem(rd_word(), mw, "trap3", ok);
          if (!ok) return;
          w = dflt(); w.ld_pc = 1'b1; w.pcmux = 2'd3;
          cyc(w, 1'b0, "trap4");
        end
      end
      default: ;
    endcase
    exp_cnt++;
  endtask

  // Reset raised between clock edges; its effect must show before the next edge.
  task automatic async_reset(input string nm);
    #2 reset = 1'b1;
    #1;
    chk({nm, "_err"}, ifm.mem_error, 0);
    chk({nm, "_ill"}, ifm.illegal_op, 0);
    chk({nm, "_cnt"}, ifm.instr_count, 0);
    chk({nm, "_fetch1"}, {ifm.load_mar, ifm.load_pc, ifm.mem_read}, 3'b110);
    exp_err = 1'b0; exp_ill = 1'b0; exp_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit ok;
    reset = 1'b1; opcode = '0; ir11 = 1'b0; branch_enable = 1'b0; mar_lsb = 1'b0;
    mem_resp = 1'b0; exp_cnt = 0; exp_err = 1'b0; exp_ill = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cnt", ifm.instr_count, 0);
    chk("rst_err", ifm.mem_error, 0);
    chk("rst_ill", ifm.illegal_op, 0);
    chk("rst_fetch1", ifm.load_mar, 1);
    @(negedge clk);
    reset = 1'b0;

    exec(op_add, 0, 0, 0, 3, 0, ok);   // response on the 4th wait cycle: no fault
    chk("cnt_after_add", ifm.instr_count, 1);
    chk("no_fault_at_limit", ifm.mem_error, 0);
    exec(op_and, 0, 0, 0, 0, 0, ok);
    exec(op_not, 0, 0, 0, 1, 0, ok);
    exec(op_br,  0, 1, 0, 0, 0, ok);
    exec(op_br,  0, 0, 0, 0, 0, ok);
    exec(op_ldr, 0, 0, 0, 0, 2, ok);
    exec(op_ldb, 0, 0, 1, 0, 1, ok);
    exec(op_str, 0, 0, 0, 0, 0, ok);
    exec(op_stb, 0, 0, 1, 0, 2, ok);
    chk("stb_hi_lane", seen_be, 2'b10);
    exec(op_stb, 0, 0, 0, 0, 1, ok);
    chk("stb_lo_lane", seen_be, 2'b01);
    chk("ni_ill_before_ldi", ifn.illegal_op, 0);
    exec(op_ldi, 0, 0, 0, 0, 1, ok);
    chk("ni_ill_after_ldi", ifn.illegal_op, 1);
    chk("ni_cnt_frozen", ifn.instr_count, 10);
    exec(op_sti,  0, 0, 0, 0, 0, ok);
    exec(op_lea,  0, 0, 0, 0, 0, ok);
    exec(op_jmp,  0, 0, 0, 0, 0, ok);
    exec(op_jsr,  1, 0, 0, 0, 0, ok);
    exec(op_jsr,  0, 0, 0, 0, 0, ok);
    exec(op_trap, 0, 0, 0, 0, 3, ok);
    chk("trap1_dest_r7", seen_dest, 1);
    chk("trap4_pcmux_mdr", seen_pcmux, 2'd3);
    chk("cnt_wrap_17", ifm.instr_count, 1);

    exec(op_add, 0, 0, 0, TMO, 0, ok);   // never answered: watchdog fault
    chk("fault_err", ifm.mem_error, 1);
    chk("fault_no_read", ifm.mem_read, 0);
    async_reset("rst_fault");

    exec(4'b1010, 0, 0, 0, 0, 0, ok);
    chk("illegal_flag", ifm.illegal_op, 1);
    async_reset("rst_illegal");

    exec(op_add, 0, 0, 0, 0, 0, ok);
    chk("cnt_restart", ifm.instr_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
